cmult_pipe: RTL and testbench



---
 rtl/cmult_pkg.sv | 24 ++
 rtl/cmult_if.sv | 29 ++
 rtl/cmult_round_sat.sv | 32 +++
 rtl/cmult_pipe.sv | 112 +++++++++++
 tb/tb_cmult_pipe.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cmult_pkg.sv
// Shared widths, types and Q-format constants for the pipelined complex multiplier.
package cmult_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  // Helper results are sized for operands up to 64 bits and then cast down by the user.
  localparam int unsigned ACC_MAX_W  = 130;

  typedef logic signed [DATA_W_DEF-1:0]   operand_t;
  typedef logic signed [DATA_W_DEF:0]     preadd_t;
  typedef logic signed [2*DATA_W_DEF+1:0] acc_t;

  function automatic logic signed [ACC_MAX_W-1:0] ROUND_CONST(input int unsigned frac_w);
    return ACC_MAX_W'(1) << (frac_w - 1);
  endfunction

  function automatic logic signed [ACC_MAX_W-1:0] SAT_MAX(input int unsigned data_w);
    return (ACC_MAX_W'(1) << (data_w - 1)) - ACC_MAX_W'(1);
  endfunction

  function automatic logic signed [ACC_MAX_W-1:0] SAT_MIN(input int unsigned data_w);
    return -(ACC_MAX_W'(1) << (data_w - 1));
  endfunction

endpackage

// File: rtl/cmult_if.sv
// Operand/result handshake bundle for cmult_pipe.
interface cmult_if
  import cmult_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_conj;
  logic signed [DATA_W-1:0] a_re;
  logic signed [DATA_W-1:0] a_im;
  logic signed [DATA_W-1:0] b_re;
  logic signed [DATA_W-1:0] b_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] s_re;
  logic signed [DATA_W-1:0] s_im;
  logic                     sat;

  modport master (
    output in_valid, in_conj, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, s_re, s_im, sat
  );

  modport slave (
    input  in_valid, in_conj, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, s_re, s_im, sat
  );
endinterface

// File: rtl/cmult_round_sat.sv
// Round-half-up, shift back to Q(FRAC_W) and clip a wide accumulator to DATA_W bits.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = DATA_W - 2
) (
  input  logic signed [2*DATA_W+1:0] acc_i,
  output logic signed [DATA_W-1:0]   y_o,
  output logic                       clip_o
);
  localparam int unsigned ACC_W = 2*DATA_W + 2;
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(ROUND_CONST(FRAC_W));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX(DATA_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN(DATA_W));

  // |acc| stays below 2^(2*DATA_W), so adding RND cannot overflow ACC_W.
  logic signed [ACC_W-1:0] shifted;
  assign shifted = (acc_i + RND) >>> FRAC_W;

  always_comb begin
    y_o    = shifted[DATA_W-1:0];
    clip_o = 1'b0;
    if (shifted > MAX_V) begin
      y_o    = MAX_V[DATA_W-1:0];
      clip_o = 1'b1;
    end else if (shifted < MIN_V) begin
      y_o    = MIN_V[DATA_W-1:0];
      clip_o = 1'b1;
    end
  end
endmodule

// File: rtl/cmult_pipe.sv
// Three-stage Gauss complex multiplier (pre-add, 3 products, round/clip) with a
// single global enable so a stalled output freezes every stage together.
module cmult_pipe
  import cmult_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = DATA_W - 2
) (
  input logic     clk,
  input logic     rst_n,
  cmult_if.slave  bus
);
  localparam int unsigned PRE_W = DATA_W + 1;
  localparam int unsigned ACC_W = 2*DATA_W + 2;

  logic en;

  logic                     v1_q, v2_q, out_valid_q;
  logic signed [PRE_W-1:0]  pa1_q, pb1_q, pc1_q;
  logic signed [DATA_W-1:0] ar1_q, ai1_q, br1_q;
  logic signed [ACC_W-1:0]  k1_q, k2_q, k3_q;
  logic signed [DATA_W-1:0] s_re_q, s_im_q;
  logic                     sat_q;

  logic signed [PRE_W-1:0]  ar_x, ai_x, br_x, bi_x, bim_d;
  logic signed [PRE_W-1:0]  pa_d, pb_d, pc_d;
  logic signed [ACC_W-1:0]  ar1_w, ai1_w, br1_w, pa1_w, pb1_w, pc1_w;
  logic signed [ACC_W-1:0]  k1_d, k2_d, k3_d;
  logic signed [ACC_W-1:0]  re_acc, im_acc;
  logic signed [DATA_W-1:0] s_re_d, s_im_d;
  logic                     clip_re, clip_im;

  assign en          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // One extra bit makes -(-2^(DATA_W-1)) exact for the conjugate path.
  assign ar_x  = {bus.a_re[DATA_W-1], bus.a_re};
  assign ai_x  = {bus.a_im[DATA_W-1], bus.a_im};
  assign br_x  = {bus.b_re[DATA_W-1], bus.b_re};
  assign bi_x  = {bus.b_im[DATA_W-1], bus.b_im};
  assign bim_d = bus.in_conj ? -bi_x : bi_x;
  assign pa_d  = ar_x + ai_x;
  assign pb_d  = bim_d - br_x;
  assign pc_d  = br_x + bim_d;

  assign ar1_w = {{(ACC_W-DATA_W){ar1_q[DATA_W-1]}}, ar1_q};
  assign ai1_w = {{(ACC_W-DATA_W){ai1_q[DATA_W-1]}}, ai1_q};
  assign br1_w = {{(ACC_W-DATA_W){br1_q[DATA_W-1]}}, br1_q};
  assign pa1_w = {{(ACC_W-PRE_W){pa1_q[PRE_W-1]}}, pa1_q};
  assign pb1_w = {{(ACC_W-PRE_W){pb1_q[PRE_W-1]}}, pb1_q};
  assign pc1_w = {{(ACC_W-PRE_W){pc1_q[PRE_W-1]}}, pc1_q};

  assign k1_d = br1_w * pa1_w;
  assign k2_d = ar1_w * pb1_w;
  assign k3_d = ai1_w * pc1_w;

  assign re_acc = k1_q - k3_q;
  assign im_acc = k1_q + k2_q;

  cmult_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rs_re (
    .acc_i  (re_acc),
    .y_o    (s_re_d),
    .clip_o (clip_re)
  );

  cmult_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rs_im (
    .acc_i  (im_acc),
    .y_o    (s_im_d),
    .clip_o (clip_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      pa1_q       <= '0;
      pb1_q       <= '0;
      pc1_q       <= '0;
      ar1_q       <= '0;
      ai1_q       <= '0;
      br1_q       <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      k3_q        <= '0;
      s_re_q      <= '0;
      s_im_q      <= '0;
      sat_q       <= 1'b0;
    end else if (en) begin
      v1_q        <= bus.in_valid;
      pa1_q       <= pa_d;
      pb1_q       <= pb_d;
      pc1_q       <= pc_d;
      ar1_q       <= bus.a_re;
      ai1_q       <= bus.a_im;
      br1_q       <= bus.b_re;
      v2_q        <= v1_q;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      k3_q        <= k3_d;
      out_valid_q <= v2_q;
      s_re_q      <= s_re_d;
      s_im_q      <= s_im_d;
      sat_q       <= clip_re | clip_im;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s_re      = s_re_q;
  assign bus.s_im      = s_im_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_cmult_pipe.sv
// Directed and backpressure checks of cmult_pipe at DATA_W=16, FRAC_W=14 (1.0 = 16384).
module tb_cmult_pipe;
  typedef logic signed [63:0] w64_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmult_if #(.DATA_W(16)) bus ();

  cmult_pipe #(.DATA_W(16), .FRAC_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input w64_t obs, input w64_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic w64_t rnd_sat(input w64_t x, output logic c);
    w64_t r;
    r = (x + 64'sd8192) >>> 14;
    c = 1'b0;
    if (r > 64'sd32767) begin
      r = 64'sd32767;
      c = 1'b1;
    end else if (r < -64'sd32768) begin
      r = -64'sd32768;
      c = 1'b1;
    end
    return r;
  endfunction

  task automatic model(input w64_t ar, input w64_t ai, input w64_t br, input w64_t bi,
                       input logic cj, output w64_t re, output w64_t im, output logic st);
    w64_t bi2;
    logic c1, c2;
    bi2 = cj ? -bi : bi;
    re  = rnd_sat(ar*br - ai*bi2, c1);
    im  = rnd_sat(ar*bi2 + ai*br, c2);
    st  = c1 | c2;
  endtask

  task automatic drive(input logic signed [15:0] ar, input logic signed [15:0] ai,
                       input logic signed [15:0] br, input logic signed [15:0] bi,
                       input logic cj);
    bus.a_re    = ar;
    bus.a_im    = ai;
    bus.b_re    = br;
    bus.b_im    = bi;
    bus.in_conj = cj;
  endtask

  task automatic directed(input string tag,
                          input logic signed [15:0] ar, input logic signed [15:0] ai,
                          input logic signed [15:0] br, input logic signed [15:0] bi,
                          input logic cj, input w64_t e_re, input w64_t e_im, input logic e_sat);
    int lat;
    drive(ar, ai, br, bi, cj);
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 10);
    chk({tag, "_latency"}, 64'(lat), 64'sd3);
    chk({tag, "_re"}, 64'(bus.s_re), e_re);
    chk({tag, "_im"}, 64'(bus.s_im), e_im);
    chk({tag, "_sat"}, 64'(bus.sat), 64'(e_sat));
    @(posedge clk); #1;
  endtask

  w64_t q_re[$];
  w64_t q_im[$];
  logic q_sat[$];

  initial begin
    int   sent, got, cyc;
    logic stall_prev;
    w64_t h_re, h_im, m_re, m_im;
    logic h_sat, m_sat;
    logic signed [15:0] r_ar, r_ai, r_br, r_bi;
    logic r_cj;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'sd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'sd1);
    chk("rst_s_re", 64'(bus.s_re), 64'sd0);
    chk("rst_s_im", 64'(bus.s_im), 64'sd0);
    chk("rst_sat", 64'(bus.sat), 64'sd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'sd1);
    @(posedge clk); #1;

    directed("basic", 16384, 0, 0, 16384, 1'b0, 0, 16384, 1'b0);
    directed("conj_off", 8192, 8192, 8192, -8192, 1'b0, 8192, 0, 1'b0);
    directed("conj_on", 8192, 8192, 8192, 8192, 1'b1, 8192, 0, 1'b0);
    directed("conj_j", 0, 16384, 0, 16384, 1'b1, 16384, 0, 1'b0);
    directed("rnd_pos", 1, 0, 8192, 0, 1'b0, 1, 0, 1'b0);
    directed("rnd_neg1", -1, 0, 8192, 0, 1'b0, 0, 0, 1'b0);
    directed("rnd_neg3", -3, 0, 8192, 0, 1'b0, -1, 0, 1'b0);
    directed("sat_sq", -32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1);
    directed("sat_mix", -32768, -32768, -32768, 32767, 1'b0, 32767, 2, 1'b1);

    // Random stream with pseudo-random output backpressure.
    sent = 0; got = 0; cyc = 0;
    stall_prev = 1'b0;
    h_re = '0; h_im = '0; h_sat = 1'b0;
    r_ar = 16'($urandom); r_ai = 16'($urandom);
    r_br = 16'($urandom); r_bi = 16'($urandom);
    r_cj = 1'($urandom);
    while (got < 10 && cyc < 300) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid  = (sent < 10);
      drive(r_ar, r_ai, r_br, r_bi, r_cj);
      #1;
      if (bus.out_valid && !bus.out_ready)
        chk("bp_in_ready", 64'(bus.in_ready), 64'sd0);
      if (stall_prev) begin
        chk("bp_hold_valid", 64'(bus.out_valid), 64'sd1);
        chk("bp_hold_re", 64'(bus.s_re), h_re);
        chk("bp_hold_im", 64'(bus.s_im), h_im);
        chk("bp_hold_sat", 64'(bus.sat), 64'(h_sat));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      h_re  = 64'(bus.s_re);
      h_im  = 64'(bus.s_im);
      h_sat = bus.sat;
      if (bus.out_valid && bus.out_ready) begin
        if (q_re.size() == 0) begin
          chk("bp_extra_output", 64'(q_re.size()), 64'sd1);
        end else begin
          chk("bp_re", 64'(bus.s_re), q_re.pop_front());
          chk("bp_im", 64'(bus.s_im), q_im.pop_front());
          chk("bp_sat", 64'(bus.sat), 64'(q_sat.pop_front()));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(64'(r_ar), 64'(r_ai), 64'(r_br), 64'(r_bi), r_cj, m_re, m_im, m_sat);
        q_re.push_back(m_re);
        q_im.push_back(m_im);
        q_sat.push_back(m_sat);
        sent++;
        r_ar = 16'($urandom); r_ai = 16'($urandom);
        r_br = 16'($urandom); r_bi = 16'($urandom);
        r_cj = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_count", 64'(got), 64'sd10);
    chk("bp_left", 64'(q_re.size()), 64'sd0);
    @(posedge clk); #1;

    // Reset with three transactions in flight.
    drive(-32768, 0, -32768, 0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(16384, 0, 8192, 4096, 1'b0);
    @(posedge clk); #1;
    drive(8192, 8192, 8192, 8192, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_pre_valid", 64'(bus.out_valid), 64'sd1);
    chk("mid_pre_re", 64'(bus.s_re), 64'sd32767);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'sd0);
    chk("mid_rst_re", 64'(bus.s_re), 64'sd0);
    chk("mid_rst_im", 64'(bus.s_im), 64'sd0);
    chk("mid_rst_sat", 64'(bus.sat), 64'sd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(bus.in_ready), 64'sd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 64'(bus.out_valid), 64'sd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
